resource_pool_lock: RTL and testbench

- Responder side of the per-SIC lock handshake (req / req_issue_id / release_lock -> grant) used for the shared ALU and memory pools.
- Arbitrates NUM_UNITS identical units among NUM_SICS requesters, oldest issue ID first.
- Holds each grant until the owner releases it.
- Reports the unit index per SIC so the datapath crossbar can route the owner's request to its unit.

---
 rtl/resource_pool_lock.sv | 139 +++++++++++++
 tb/tb_resource_pool_lock.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/resource_pool_lock.sv
// Lock-handshake responder for a pool of identical units: grants free units to
// requesting SICs oldest-issue-ID first and holds each grant until released.

module resource_pool_lock_age #(
  parameter int ID_WIDTH = 4
) (
  input  logic [ID_WIDTH-1:0] issue_id,
  input  logic [ID_WIDTH-1:0] oldest_id,
  output logic [ID_WIDTH-1:0] age
);
  // Modular distance from the oldest in-flight ID; wraps naturally.
  assign age = issue_id - oldest_id;
endmodule

module resource_pool_lock #(
  parameter int NUM_SICS  = 4,
  parameter int NUM_UNITS = 1,
  parameter int ID_WIDTH  = 4,
  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int CW = $clog2(NUM_UNITS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_SICS-1:0]          req,
  input  logic [NUM_SICS*ID_WIDTH-1:0] req_issue_id,
  input  logic [NUM_SICS-1:0]          release_lock,
  input  logic [ID_WIDTH-1:0]          oldest_issue_id,
  output logic [NUM_SICS-1:0]          grant,
  output logic [NUM_SICS*UW-1:0]       grant_unit,
  output logic [CW-1:0]                units_busy
);
  localparam int SW = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;
  localparam int RW = $clog2(NUM_SICS + 1);

  logic [NUM_UNITS-1:0]               busy_q, busy_d;
  logic [NUM_UNITS-1:0][SW-1:0]       owner_q, owner_d;
  logic [NUM_SICS-1:0]                grant_q, grant_d;
  logic [NUM_SICS-1:0][UW-1:0]        unit_q, unit_d;
  logic [CW-1:0]                      busy_cnt_q, busy_cnt_d;

  logic [NUM_SICS-1:0][ID_WIDTH-1:0]  age;
  logic [NUM_SICS-1:0]                elig;
  logic [NUM_SICS-1:0][RW-1:0]        rank;
  logic [RW-1:0]                      free_cnt;

  genvar g;
  for (g = 0; g < NUM_SICS; g++) begin : g_age
    resource_pool_lock_age #(.ID_WIDTH(ID_WIDTH)) u_age (
      .issue_id  (req_issue_id[g*ID_WIDTH +: ID_WIDTH]),
      .oldest_id (oldest_issue_id),
      .age       (age[g])
    );
  end

  assign elig = req & ~grant_q;

  // Rank = number of eligible requesters strictly ahead (older, or same age at lower index).
  always_comb begin
    rank = '0;
    for (int i = 0; i < NUM_SICS; i++) begin
      for (int j = 0; j < NUM_SICS; j++) begin
        if (elig[j] && (j != i) &&
            ((age[j] < age[i]) || ((age[j] == age[i]) && (j < i))))
          rank[i] = rank[i] + RW'(1);
      end
    end
  end

  // The k-th pre-edge free unit (lowest index first) goes to the rank-k requester.
  always_comb begin
    busy_d   = busy_q;
    owner_d  = owner_q;
    free_cnt = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (busy_q[u]) begin
        if (release_lock[owner_q[u]] || !req[owner_q[u]])
          busy_d[u] = 1'b0;
      end else begin
        for (int i = 0; i < NUM_SICS; i++) begin
          if (elig[i] && (rank[i] == free_cnt)) begin
            busy_d[u]  = 1'b1;
            owner_d[u] = SW'(i);
          end
        end
        free_cnt = free_cnt + RW'(1);
      end
    end
  end

  always_comb begin
    grant_d    = '0;
    unit_d     = '0;
    busy_cnt_d = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (busy_d[u]) begin
        grant_d[owner_d[u]] = 1'b1;
        unit_d[owner_d[u]]  = UW'(u);
        busy_cnt_d          = busy_cnt_d + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      owner_q    <= '0;
      grant_q    <= '0;
      unit_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      unit_q     <= unit_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign grant      = grant_q;
  assign grant_unit = unit_q;
  assign units_busy = busy_cnt_q;

  // Ownership invariants on the registered state.
  logic [NUM_SICS-1:0][CW-1:0] owner_cnt;
  always_comb begin
    owner_cnt = '0;
    for (int u = 0; u < NUM_UNITS; u++)
      if (busy_q[u]) owner_cnt[owner_q[u]] = owner_cnt[owner_q[u]] + CW'(1);
  end

  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_SICS; i++) begin
        assert (owner_cnt[i] <= CW'(1)) else $error("unit owner shared by SIC %0d", i);
        assert (grant_q[i] == (owner_cnt[i] == CW'(1))) else $error("grant/owner disagree for SIC %0d", i);
      end
    end
  end
endmodule

// File: tb/tb_resource_pool_lock.sv
// Directed bench: one single-unit and one dual-unit pool driven through the
// lock handshake scenarios, checked with immediate assertions.
module tb_resource_pool_lock;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  req1, rel1, grant1, gu1;
  logic [15:0] id1;
  logic [3:0]  old1;
  logic [0:0]  busy1;

  logic [3:0]  req2, rel2, grant2, gu2;
  logic [15:0] id2;
  logic [3:0]  old2;
  logic [1:0]  busy2;

  int n_assert = 0;
  int n_fail   = 0;

  resource_pool_lock #(.NUM_SICS(4), .NUM_UNITS(1), .ID_WIDTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .req_issue_id(id1), .release_lock(rel1),
    .oldest_issue_id(old1), .grant(grant1), .grant_unit(gu1), .units_busy(busy1)
  );

  resource_pool_lock #(.NUM_SICS(4), .NUM_UNITS(2), .ID_WIDTH(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .req_issue_id(id2), .release_lock(rel2),
    .oldest_issue_id(old2), .grant(grant2), .grant_unit(gu2), .units_busy(busy2)
  );

  function automatic logic [15:0] ids(input logic [3:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req1 = '0; rel1 = '0; id1 = '0; old1 = '0;
    req2 = '0; rel2 = '0; id2 = '0; old2 = '0;
    #2;
    chk("rst_grant1", 32'(grant1), 32'h0);
    chk("rst_unit1",  32'(gu1),    32'h0);
    chk("rst_busy1",  32'(busy1),  32'h0);
    chk("rst_grant2", 32'(grant2), 32'h0);
    chk("rst_busy2",  32'(busy2),  32'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Single grant, one edge after req
    old1 = 4'd5; id1 = ids(0, 0, 5, 0); req1 = 4'b0100;
    step();
    chk("t1_grant", 32'(grant1), 32'b0100);
    chk("t1_unit",  32'(gu1[2]), 32'h0);
    chk("t1_busy",  32'(busy1),  32'h1);
    req1 = 4'b0000; rel1 = 4'b0100;
    step(); rel1 = '0;
    chk("t1_rel", 32'(grant1), 32'h0);
    chk("t1_rel_busy", 32'(busy1), 32'h0);

    // Oldest first, then one idle cycle between owners
    old1 = 4'd6; id1 = ids(9, 0, 0, 7); req1 = 4'b1001;
    step();
    chk("t2_first", 32'(grant1), 32'b1000);
    step();
    chk("t2_hold", 32'(grant1), 32'b1000);
    req1 = 4'b0001; rel1 = 4'b1000;
    step(); rel1 = '0;
    chk("t2_idle", 32'(grant1), 32'h0);
    chk("t2_idle_busy", 32'(busy1), 32'h0);
    step();
    chk("t2_next", 32'(grant1), 32'b0001);
    chk("t2_next_unit", 32'(gu1[0]), 32'h0);
    req1 = 4'b0000;
    step();
    chk("t2_drop", 32'(grant1), 32'h0);

    // Wrap-around age key
    old1 = 4'd14; id1 = ids(0, 1, 15, 0); req1 = 4'b0110;
    step();
    chk("t3_wrap", 32'(grant1), 32'b0100);
    req1 = 4'b0010; rel1 = 4'b0100;
    step(); rel1 = '0;
    chk("t3_idle", 32'(grant1), 32'h0);
    step();
    chk("t3_next", 32'(grant1), 32'b0010);
    req1 = 4'b0000;
    step();
    chk("t3_abort", 32'(grant1), 32'h0);

    // Sticky ownership and ignored stray release
    old1 = 4'd0; id1 = ids(2, 4, 0, 0); req1 = 4'b0010;
    step();
    chk("t5_own", 32'(grant1), 32'b0010);
    req1 = 4'b0011;
    step();
    chk("t5_sticky", 32'(grant1), 32'b0010);
    rel1 = 4'b0001;
    step(); rel1 = '0;
    chk("t5_stray", 32'(grant1), 32'b0010);
    chk("t5_stray_busy", 32'(busy1), 32'h1);
    req1 = 4'b0001; rel1 = 4'b0010;
    step(); rel1 = '0;
    chk("t5_idle", 32'(grant1), 32'h0);
    step();
    chk("t5_older", 32'(grant1), 32'b0001);
    // Release with req still high: freed now, regranted next edge
    rel1 = 4'b0001;
    step(); rel1 = '0;
    chk("t5_relreq", 32'(grant1), 32'h0);
    step();
    chk("t5_regrant", 32'(grant1), 32'b0001);
    req1 = 4'b0000;
    step();

    // Two units filled on one edge
    old2 = 4'd0; id2 = ids(3, 1, 2, 0); req2 = 4'b1111;
    step();
    chk("t4_grant", 32'(grant2), 32'b1010);
    chk("t4_unit",  32'(gu2),    32'b0010);
    chk("t4_busy",  32'(busy2),  32'h2);
    step();
    chk("t4_wait", 32'(grant2), 32'b1010);
    req2 = 4'b0111; rel2 = 4'b1000;
    step(); rel2 = '0;
    chk("t4_rel", 32'(grant2), 32'b0010);
    chk("t4_rel_busy", 32'(busy2), 32'h1);
    req2 = 4'b1111;
    step();
    chk("t4_refill", 32'(grant2), 32'b1010);
    chk("t4_refill_unit", 32'(gu2), 32'b0010);
    req2 = 4'b0111; rel2 = 4'b1000;
    step(); rel2 = '0;
    req2 = 4'b1111;
    step();
    // SIC3 re-raised req after the drop, age 0 beats SIC2
    chk("t4_again", 32'(grant2), 32'b1010);
    req2 = 4'b0111;
    step();
    chk("t4_drop3", 32'(grant2), 32'b0010);
    step();
    chk("t4_sic2", 32'(grant2), 32'b0110);
    chk("t4_sic2_unit", 32'(gu2), 32'b0010);
    chk("t4_sic2_busy", 32'(busy2), 32'h2);

    // Asynchronous reset mid-hold, then fresh arbitration
    req2 = 4'b1111;
    rst_n = 1'b0;
    #1;
    chk("t6_async_grant", 32'(grant2), 32'h0);
    chk("t6_async_busy",  32'(busy2),  32'h0);
    chk("t6_async_unit",  32'(gu2),    32'h0);
    #2 rst_n = 1'b1;
    #1;
    chk("t6_hold_low", 32'(grant2), 32'h0);
    step();
    chk("t6_regrant", 32'(grant2), 32'b1010);
    chk("t6_unit",    32'(gu2),    32'b0010);
    chk("t6_busy",    32'(busy2),  32'h2);
    req2 = '0;
    step();
    chk("t6_clear", 32'(busy2), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
